// File: rtl/sig_mon_pkg.sv
// sig_mon_pkg: state encoding and counter width shared by the signature-sequence monitor.
package sig_mon_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PASS,
    FAIL,
    TIMEOUT
  } state_e;

endpackage

// File: rtl/sig_mon_filter.sv
// sig_mon_filter: presents a bus value only once it has held for STABLE_CYC consecutive cycles.
// Only instantiated when SIG_FILTER_EN is defined; clr_i restarts the stability search.
module sig_mon_filter
  import sig_mon_pkg::*;
#(
  parameter int  WIDTH      = 16,
  parameter int  STABLE_CYC = 4,
  localparam int RW         = $clog2(STABLE_CYC + 1)
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] hold_q;
  logic [RW-1:0]    run_q;
  logic [RW-1:0]    run_d;
  logic             valid_q;

  // run_q == 0 means nothing sampled since clear, so the first sample always starts a new run
  always_comb begin
    run_d = RW'(1);
    if (run_q != '0 && data_i == last_q)
      run_d = (run_q == RW'(STABLE_CYC)) ? run_q : run_q + 1'b1;
  end

  always_ff @(posedge mclk) begin
    if (!reset_n || clr_i) begin
      last_q  <= '0;
      hold_q  <= '0;
      run_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      last_q <= data_i;
      run_q  <= run_d;
      if (run_d == RW'(STABLE_CYC)) begin
        hold_q  <= data_i;
        valid_q <= 1'b1;
      end
    end
  end

  assign data_o  = hold_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/sig_seq_monitor.sv
// sig_seq_monitor: ordered checkpoint-signature monitor with fail-signature and cycle timeout.
// Define SIG_FILTER_EN to route check_i through sig_mon_filter before matching.
//   state   | meaning
//   IDLE    | waiting for arm_i, nothing matches
//   RUN     | matching signatures in order, counting cycles
//   PASS    | every step matched in order
//   FAIL    | fail signature seen before completion
//   TIMEOUT | TIMEOUT_CYC cycles elapsed before completion
module sig_seq_monitor
  import sig_mon_pkg::*;
#(
  parameter int          WIDTH       = 16,
  parameter int          NUM_STEPS   = 2,
  parameter int unsigned TIMEOUT_CYC = 30000,
  parameter int          STABLE_CYC  = 4,
  localparam int         SW          = $clog2(NUM_STEPS + 1)
) (
  input  logic                       mclk,
  input  logic                       reset_n,
  input  logic                       arm_i,
  input  logic [WIDTH-1:0]           check_i,
  input  logic [NUM_STEPS*WIDTH-1:0] exp_sig_i,
  input  logic [WIDTH-1:0]           fail_sig_i,
  output logic                       started_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic                       fail_o,
  output logic                       timeout_o,
  output logic [SW-1:0]              step_o,
  output logic [CNT_W-1:0]           cyc_cnt_o
);

  state_e           state_q;
  logic [SW-1:0]    step_q;
  logic [CNT_W-1:0] cyc_cnt_q;
  logic             started_q, done_q, pass_q, fail_q, timeout_q;
  logic [WIDTH-1:0] samp;
  logic             samp_vld;
  logic [WIDTH-1:0] exp_cur;
  logic             sig_hit, fail_hit, tmo_hit, last_step;

  if (NUM_STEPS < 1 || STABLE_CYC < 1) begin : g_param_chk
    $error("sig_seq_monitor: NUM_STEPS and STABLE_CYC must be >= 1");
  end

`ifdef SIG_FILTER_EN
  sig_mon_filter #(
    .WIDTH      (WIDTH),
    .STABLE_CYC (STABLE_CYC)
  ) u_filter (
    .mclk    (mclk),
    .reset_n (reset_n),
    .clr_i   (arm_i),
    .data_i  (check_i),
    .data_o  (samp),
    .valid_o (samp_vld)
  );
`else
  assign samp     = check_i;
  assign samp_vld = 1'b1;
`endif

  always_comb begin
    exp_cur = '0;
    for (int k = 0; k < NUM_STEPS; k++)
      if (step_q == SW'(k)) exp_cur = exp_sig_i[k*WIDTH +: WIDTH];
  end

  assign last_step = (step_q == SW'(NUM_STEPS - 1));
  assign sig_hit   = (state_q == RUN) && samp_vld && (samp == exp_cur);
  assign fail_hit  = (state_q == RUN) && samp_vld && (samp == fail_sig_i);
  assign tmo_hit   = (cyc_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // A non-final match on the timeout cycle still advances the step before timing out
  always_ff @(posedge mclk) begin
    if (!reset_n || arm_i) begin
      state_q   <= reset_n ? RUN : IDLE;
      step_q    <= '0;
      cyc_cnt_q <= '0;
      started_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (state_q == RUN) begin
      if (cyc_cnt_q != '1) cyc_cnt_q <= cyc_cnt_q + 1'b1;
      if (sig_hit) begin
        step_q <= step_q + 1'b1;
        if (step_q == '0) started_q <= 1'b1;
      end
      if (sig_hit && last_step) begin
        state_q <= PASS;
        pass_q  <= 1'b1;
        done_q  <= 1'b1;
      end else if (!sig_hit && fail_hit) begin
        state_q <= FAIL;
        fail_q  <= 1'b1;
        done_q  <= 1'b1;
      end else if (tmo_hit) begin
        state_q   <= TIMEOUT;
        timeout_q <= 1'b1;
        done_q    <= 1'b1;
      end
    end
  end

  assign started_o = started_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign fail_o    = fail_q;
  assign timeout_o = timeout_q;
  assign step_o    = step_q;
  assign cyc_cnt_o = cyc_cnt_q;

endmodule

// File: tb/tb_sig_seq_monitor.sv
// Bench for sig_seq_monitor: a 2-step default instance and a 4-step/100-cycle-timeout instance
// share stimulus; constant tables, hand sequences and a random run against a behavioural model.
`timescale 1ns/1ps
module tb_sig_seq_monitor;

  localparam logic [15:0] FSIG   = 16'hAB6F;
  localparam int          STABLE = 4;
`ifdef SIG_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FLT = 3, M_TMO = 4;
  localparam logic [31:0] EXP_A = {16'hAB6A, 16'hAB60};
  localparam logic [63:0] EXP_B = {16'hAB63, 16'hAB62, 16'hAB61, 16'hAB60};

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        arm_i = 1'b0;
  logic [15:0] check_i = '0;

  logic        a_started, a_done, a_pass, a_fail, a_timeout;
  logic [1:0]  a_step;
  logic [31:0] a_cyc;
  logic        b_started, b_done, b_pass, b_fail, b_timeout;
  logic [2:0]  b_step;
  logic [31:0] b_cyc;

  always #5 mclk = ~mclk;

  sig_seq_monitor dut_a (
    .mclk(mclk), .reset_n(reset_n), .arm_i(arm_i), .check_i(check_i),
    .exp_sig_i(EXP_A), .fail_sig_i(FSIG),
    .started_o(a_started), .done_o(a_done), .pass_o(a_pass), .fail_o(a_fail),
    .timeout_o(a_timeout), .step_o(a_step), .cyc_cnt_o(a_cyc)
  );

  sig_seq_monitor #(.NUM_STEPS(4), .TIMEOUT_CYC(100)) dut_b (
    .mclk(mclk), .reset_n(reset_n), .arm_i(arm_i), .check_i(check_i),
    .exp_sig_i(EXP_B), .fail_sig_i(FSIG),
    .started_o(b_started), .done_o(b_done), .pass_o(b_pass), .fail_o(b_fail),
    .timeout_o(b_timeout), .step_o(b_step), .cyc_cnt_o(b_cyc)
  );

  int checks = 0;
  int failures = 0;
  int cyc_no = 0;

  // Behavioural reference: outcome, matched-step count and elapsed cycles per instance
  int          m_st[2];
  int          m_step[2];
  longint      m_cyc[2];
  bit          m_started[2];
  logic [15:0] hist[$];
  logic [15:0] fv;
  bit          fvld;

  function automatic logic [15:0] exp_of(int d, int k);
    if (d == 0) return (k == 0) ? 16'hAB60 : 16'hAB6A;
    return 16'hAB60 + 16'(k);
  endfunction

  function automatic int nsteps(int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic longint tmo(int d);
    return (d == 0) ? 64'd30000 : 64'd100;
  endfunction

  task automatic model_edge(input logic rst_v, input logic arm_v, input logic [15:0] c);
    logic [15:0] v;
    bit          vv, same;
    v  = FILT ? fv : c;
    vv = FILT ? fvld : 1'b1;
    if (!rst_v || arm_v) begin
      for (int d = 0; d < 2; d++) begin
        m_st[d]      = rst_v ? M_RUN : M_IDLE;
        m_step[d]    = 0;
        m_cyc[d]     = 0;
        m_started[d] = 1'b0;
      end
      hist.delete();
      fvld = 1'b0;
      fv   = '0;
      return;
    end
    for (int d = 0; d < 2; d++) begin
      if (m_st[d] == M_RUN) begin
        if (m_cyc[d] < 64'hFFFF_FFFF) m_cyc[d] = m_cyc[d] + 1;
        if (vv && v == exp_of(d, m_step[d])) begin
          if (m_step[d] == 0) m_started[d] = 1'b1;
          m_step[d] = m_step[d] + 1;
          if (m_step[d] == nsteps(d)) m_st[d] = M_PASS;
          else if (m_cyc[d] == tmo(d)) m_st[d] = M_TMO;
        end else if (vv && v == FSIG) begin
          m_st[d] = M_FLT;
        end else if (m_cyc[d] == tmo(d)) begin
          m_st[d] = M_TMO;
        end
      end
    end
    hist.push_back(c);
    if (hist.size() > STABLE) void'(hist.pop_front());
    if (hist.size() == STABLE) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != c) same = 1'b0;
      if (same) begin
        fv   = c;
        fvld = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc_no, got, want);
    end
  endtask

  task automatic cmp_model();
    logic [39:0] got, want;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) got = {a_started, a_done, a_pass, a_fail, a_timeout, 1'b0, a_step, a_cyc};
      else        got = {b_started, b_done, b_pass, b_fail, b_timeout, b_step, b_cyc};
      want = {m_started[d], m_st[d] >= M_PASS, m_st[d] == M_PASS, m_st[d] == M_FLT,
              m_st[d] == M_TMO, 3'(m_step[d]), 32'(m_cyc[d])};
      check(d == 0 ? "model_a" : "model_b", 64'(got), 64'(want));
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    model_edge(reset_n, arm_i, check_i);
    cyc_no++;
    @(negedge mclk);
    cmp_model();
  endtask

  typedef struct {
    bit          arm;
    logic [15:0] chk;
    logic [4:0]  flg;   // {started, done, pass, fail, timeout}
    int          step;
    int          cyc;
  } vec_t;

  vec_t        tbl[18];
  logic [15:0] sa_v[6];
  int          sa_s[6];

  initial begin
    tbl[0]  = '{1'b0, 16'h0000, 5'b00000, 0, 0};
    tbl[1]  = '{1'b0, 16'hAB6F, 5'b00000, 0, 0};
    tbl[2]  = '{1'b0, 16'hAB60, 5'b00000, 0, 0};
    tbl[3]  = '{1'b1, 16'hAB60, 5'b00000, 0, 0};
    tbl[4]  = '{1'b0, 16'hAB60, 5'b10000, 1, 1};
    tbl[5]  = '{1'b0, 16'h1234, 5'b10000, 1, 2};
    tbl[6]  = '{1'b0, 16'hAB60, 5'b10000, 1, 3};
    tbl[7]  = '{1'b0, 16'hAB6A, 5'b11100, 2, 4};
    tbl[8]  = '{1'b0, 16'hAB6F, 5'b11100, 2, 4};
    tbl[9]  = '{1'b0, 16'hAB6A, 5'b11100, 2, 4};
    tbl[10] = '{1'b1, 16'h0000, 5'b00000, 0, 0};
    tbl[11] = '{1'b0, 16'hAB60, 5'b10000, 1, 1};
    tbl[12] = '{1'b0, 16'hAB6F, 5'b11010, 1, 2};
    tbl[13] = '{1'b0, 16'hAB6A, 5'b11010, 1, 2};
    tbl[14] = '{1'b1, 16'hAB60, 5'b00000, 0, 0};
    tbl[15] = '{1'b0, 16'hAB60, 5'b10000, 1, 1};
    tbl[16] = '{1'b1, 16'hAB6A, 5'b00000, 0, 0};
    tbl[17] = '{1'b0, 16'hAB6A, 5'b00000, 0, 1};
    sa_v = '{16'hAB60, 16'h1234, 16'hAB62, 16'hAB61, 16'hAB62, 16'hAB63};
    sa_s = '{1, 1, 1, 2, 3, 4};

    reset_n = 1'b0;
    repeat (2) tick();
    check("reset_a", 64'({a_started, a_done, a_pass, a_fail, a_timeout, a_step, a_cyc}), 64'd0);
    check("reset_b", 64'({b_started, b_done, b_pass, b_fail, b_timeout, b_step, b_cyc}), 64'd0);
    reset_n = 1'b1;

`ifndef SIG_FILTER_EN
    for (int i = 0; i < 18; i++) begin
      arm_i   = tbl[i].arm;
      check_i = tbl[i].chk;
      tick();
      check("tbl_flags", 64'({a_started, a_done, a_pass, a_fail, a_timeout}), 64'(tbl[i].flg));
      check("tbl_step", 64'(a_step), 64'(tbl[i].step));
      check("tbl_cyc", 64'(a_cyc), 64'(tbl[i].cyc));
    end

    // Four-step order: intermediate code ignored, out-of-order step does not advance
    arm_i = 1'b1; check_i = '0; tick(); arm_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_i = sa_v[i];
      tick();
      check("order_step", 64'(b_step), 64'(sa_s[i]));
    end
    check("order_pass", 64'({b_done, b_pass, b_fail, b_timeout}), 64'b1100);
    check("order_cyc", 64'(b_cyc), 64'd6);
`endif

    // Timeout on cycle 100 after arm, counter frozen, re-arm clears
    arm_i = 1'b1; check_i = '0; tick(); arm_i = 1'b0;
    repeat (99) tick();
    check("tmo_early", 64'({b_done, b_timeout, b_cyc}), 64'd99);
    tick();
    check("tmo_flags", 64'({b_done, b_pass, b_fail, b_timeout}), 64'b1001);
    check("tmo_cyc", 64'(b_cyc), 64'd100);
    repeat (5) tick();
    check("tmo_frozen", 64'(b_cyc), 64'd100);
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    check("rearm_clear", 64'({b_started, b_done, b_pass, b_fail, b_timeout, b_step, b_cyc}), 64'd0);

`ifndef SIG_FILTER_EN
    // Final match lands on the timeout cycle: pass wins
    arm_i = 1'b1; check_i = '0; tick(); arm_i = 1'b0;
    check_i = 16'hAB60; tick();
    check_i = 16'hAB61; tick();
    check_i = 16'hAB62; tick();
    check("race_step3", 64'(b_step), 64'd3);
    check_i = '0;
    repeat (96) tick();
    check_i = 16'hAB63; tick();
    check("race_flags", 64'({b_done, b_pass, b_fail, b_timeout}), 64'b1100);
    check("race_step", 64'(b_step), 64'd4);
    check("race_cyc", 64'(b_cyc), 64'd100);
`else
    // 3-cycle glitch must not start; a 4-cycle hold starts one cycle after it becomes stable
    arm_i = 1'b1; check_i = '0; tick(); arm_i = 1'b0;
    check_i = 16'hAB60; repeat (3) tick();
    check_i = 16'h0000; repeat (6) tick();
    check("glitch_start", 64'(a_started), 64'd0);
    check_i = 16'hAB60; repeat (4) tick();
    check("hold_latency", 64'(a_started), 64'd0);
    tick();
    check("hold_start", 64'({a_started, a_step}), 64'b101);
`endif

    for (int n = 0; n < 4000; n++) begin
      reset_n = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
      arm_i   = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 9) >= 7) begin
        case ($urandom_range(0, 8))
          0: check_i = 16'hAB60;
          1: check_i = 16'hAB61;
          2: check_i = 16'hAB62;
          3: check_i = 16'hAB63;
          4: check_i = 16'hAB6A;
          5: check_i = FSIG;
          6, 7: check_i = exp_of(1, (m_step[1] < 4) ? m_step[1] : 3);
          default: check_i = 16'($urandom);
        endcase
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
